// File: rtl/uart_pkg.sv
// Shared UART constants: byte width, default FIFO depth, line timing.
// No logic; constants only.
// Imported by the FIFO, its storage and the UART top.
package uart_pkg;
   localparam int UART_DATA_W  = 8;
   localparam int FIFO_ADDR_W  = 4;
   localparam int CLK_HZ       = 50_000_000;
   localparam int BAUD         = 115_200;
   localparam int BAUD_DIVISOR = CLK_HZ / BAUD;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side and transmitter-side signals of the UART TX FIFO.
// Pure wiring, no latency.
// wr_ready and tx_data_valid/tx_data_ack carry the flow control.
interface uart_tx_fifo_if
   import uart_pkg::*;
#(
   parameter int ADDR_W = FIFO_ADDR_W,
   parameter int DATA_W = UART_DATA_W
);
   logic [DATA_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] tx_data;
   logic              tx_data_valid;
   logic              tx_data_ack;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic              clr_overflow;

   // Producer plus transmitter side.
   modport master (
      output wr_data, wr_valid, tx_data_ack, clr_overflow,
      input  wr_ready, tx_data, tx_data_valid, level, overflow
   );

   // FIFO side.
   modport slave (
      input  wr_data, wr_valid, tx_data_ack, clr_overflow,
      output wr_ready, tx_data, tx_data_valid, level, overflow
   );
endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register file, one write port, one read port.
// Write lands on the clock edge; read is combinational (zero latency).
// No flow control; the caller gates i_we.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int ADDR_W = FIFO_ADDR_W,
   parameter int DATA_W = UART_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Storage is deliberately not reset; stale entries are never presented
   // because the control logic tracks occupancy.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a bursty producer and the UART transmitter.
// Write-to-head latency 1 cycle; pop takes effect on the ack edge.
// wr_ready = not full (registered count), writes while full are dropped and flagged.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int ADDR_W = FIFO_ADDR_W,
   parameter int DATA_W = UART_DATA_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   uart_tx_fifo_if.slave io_fifo
);
   localparam int              DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_overflow;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   // Full/empty come only from the registered count, so wr_ready never
   // depends combinationally on wr_valid or tx_data_ack.
   assign w_full  = (r_count == DEPTH_CNT);
   assign w_empty = (r_count == '0);
   assign w_push  = io_fifo.wr_valid & ~w_full;
   assign w_pop   = io_fifo.tx_data_ack & ~w_empty;

   // Pointer, occupancy and sticky overflow update.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A dropped write outranks a clear in the same cycle.
         if (io_fifo.wr_valid & w_full) begin
            r_overflow <= 1'b1;
         end else if (io_fifo.clr_overflow) begin
            r_overflow <= 1'b0;
         end
      end
   end

   uart_fifo_mem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (io_fifo.wr_data),
      .i_raddr (r_rd_ptr),
      .o_rdata (io_fifo.tx_data)
   );

   assign io_fifo.wr_ready      = ~w_full;
   assign io_fifo.tx_data_valid = ~w_empty;
   assign io_fifo.level         = r_count;
   assign io_fifo.overflow      = r_overflow;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, scoreboard-driven
// corner sequences and a behavioural UART transmitter/receiver pair.
module tb_uart_tx_fifo;
   localparam int DEPTH = 16;
   localparam int BAUD_DIVISOR = 4;

   logic clk = 1'b0;
   logic rst;
   logic txd;

   int n_tests = 0;
   int n_fail  = 0;
   int ack_cnt = 0;

   logic [7:0] sb [$];
   logic       m_ov;

   uart_tx_fifo_if u_if ();

   uart_tx_fifo u_dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .io_fifo (u_if)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic       rst;
      logic       wv;
      logic [7:0] wd;
      logic       ack;
      logic       clr;
      logic       e_rdy;
      logic       e_vld;
      logic [4:0] e_lvl;
      logic       e_ov;
      logic [7:0] e_dat;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      rst                = 1'b0;
      u_if.wr_valid      = 1'b0;
      u_if.wr_data       = 8'h00;
      u_if.tx_data_ack   = 1'b0;
      u_if.clr_overflow  = 1'b0;
   endtask

   // Compare DUT outputs against the scoreboard model.
   task automatic check_model(input string name);
      check({name, ".level"}, 32'(u_if.level), 32'(sb.size()));
      check({name, ".vld"}, 32'(u_if.tx_data_valid), 32'(sb.size() != 0));
      check({name, ".rdy"}, 32'(u_if.wr_ready), 32'(sb.size() != DEPTH));
      check({name, ".ovf"}, 32'(u_if.overflow), 32'(m_ov));
      if (sb.size() != 0) begin
         check({name, ".head"}, 32'(u_if.tx_data), 32'(sb[0]));
      end
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      m_ov = 1'b0;
   endtask

   // One cycle of stimulus with model update and output comparison.
   task automatic do_cycle(input logic wv, input logic [7:0] wd, input logic ack,
                           input logic clr, input string name);
      bit full_pre;
      full_pre = (sb.size() == DEPTH);
      u_if.wr_valid     = wv;
      u_if.wr_data      = wd;
      u_if.tx_data_ack  = ack;
      u_if.clr_overflow = clr;
      if (ack && sb.size() != 0) begin
         check({name, ".popped"}, 32'(u_if.tx_data), 32'(sb[0]));
         void'(sb.pop_front());
      end
      if (wv && !full_pre) sb.push_back(wd);
      if (wv && full_pre) m_ov = 1'b1;
      else if (clr)       m_ov = 1'b0;
      step();
      drive_idle();
      check_model(name);
   endtask

   // Behavioural transmitter: accept head, ack next cycle, shift frame on txd.
   task automatic uart_tx(input int n_bytes);
      logic [9:0] frame;
      int         wait_cnt;
      for (int k = 0; k < n_bytes; k++) begin
         wait_cnt = 0;
         while (!u_if.tx_data_valid && wait_cnt < 50) begin
            step();
            wait_cnt++;
         end
         if (!u_if.tx_data_valid) begin
            check("uart_tx.wait_valid", 32'(u_if.tx_data_valid), 32'd1);
            return;
         end
         frame = {1'b1, u_if.tx_data, 1'b0};
         for (int b = 0; b < 10; b++) begin
            txd = frame[b];
            for (int c = 0; c < BAUD_DIVISOR; c++) begin
               u_if.tx_data_ack = (b == 0 && c == 1);
               if (b == 0 && c == 1) ack_cnt++;
               step();
               if (b == 0 && c == 1 && k == n_bytes - 1) begin
                  check("uart.level_after_last_ack", 32'(u_if.level), 32'd0);
               end
            end
         end
         u_if.tx_data_ack = 1'b0;
      end
   endtask

   // Receiver: decode frames from txd and compare with the scoreboard.
   task automatic uart_rx(input int n_bytes);
      logic [7:0] got;
      int         wait_cnt;
      for (int k = 0; k < n_bytes; k++) begin
         wait_cnt = 0;
         @(negedge clk);
         while (txd !== 1'b0 && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
         end
         if (txd !== 1'b0) begin
            check("uart_rx.start_timeout", 32'(txd), 32'd0);
            return;
         end
         @(negedge clk);
         check("uart_rx.start", 32'(txd), 32'd0);
         for (int b = 0; b < 8; b++) begin
            repeat (BAUD_DIVISOR) @(negedge clk);
            got[b] = txd;
         end
         repeat (BAUD_DIVISOR) @(negedge clk);
         check("uart_rx.stop", 32'(txd), 32'd1);
         if (sb.size() == 0) begin
            check("uart_rx.unexpected_frame", 32'(got), 32'h100);
         end else begin
            check("uart_rx.byte", 32'(got), 32'(sb.pop_front()));
         end
      end
   endtask

   initial begin
      txd = 1'b1;
      m_ov = 1'b0;
      drive_idle();
      rst = 1'b1;

      //             rst wv  wd     ack clr  rdy vld lvl  ov  dat
      vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};
      vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};
      vecs[2]  = '{1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 8'h41};
      vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 8'h41};
      vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};
      vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};
      vecs[6]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 8'h11};
      vecs[7]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 8'h11};
      vecs[8]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 8'h22};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 8'h33};
      vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 8'h33};
      vecs[11] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 8'h44};
      vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};

      step();
      for (int i = 0; i < 13; i++) begin
         rst               = vecs[i].rst;
         u_if.wr_valid     = vecs[i].wv;
         u_if.wr_data      = vecs[i].wd;
         u_if.tx_data_ack  = vecs[i].ack;
         u_if.clr_overflow = vecs[i].clr;
         step();
         drive_idle();
         check($sformatf("vec%0d.rdy", i), 32'(u_if.wr_ready), 32'(vecs[i].e_rdy));
         check($sformatf("vec%0d.vld", i), 32'(u_if.tx_data_valid), 32'(vecs[i].e_vld));
         check($sformatf("vec%0d.lvl", i), 32'(u_if.level), 32'(vecs[i].e_lvl));
         check($sformatf("vec%0d.ovf", i), 32'(u_if.overflow), 32'(vecs[i].e_ov));
         if (vecs[i].e_vld) begin
            check($sformatf("vec%0d.dat", i), 32'(u_if.tx_data), 32'(vecs[i].e_dat));
         end
      end

      // Reset then idle; single byte held for 100 cycles, then one ack.
      do_reset();
      check_model("reset");
      repeat (5) do_cycle(1'b0, 8'h00, 1'b0, 1'b0, "idle");
      do_cycle(1'b1, 8'h41, 1'b0, 1'b0, "wr41");
      repeat (100) do_cycle(1'b0, 8'h00, 1'b0, 1'b0, "hold41");
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0, "ack41");

      // Fill to full, overflow attempt, drain in order, clear flag.
      for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");
      do_cycle(1'b1, 8'hFF, 1'b0, 1'b0, "wr_full");
      for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr_ovf");

      // Push and pop together while full: pop only, overflow set.
      for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "fill2");
      do_cycle(1'b1, 8'hAA, 1'b1, 1'b0, "full_push_pop");
      for (int i = 0; i < DEPTH - 1; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
      // Overflow set and clear together: set wins.
      for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, "fill3");
      do_cycle(1'b1, 8'hBB, 1'b0, 1'b1, "set_vs_clr");
      for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b1, "drain3");

      // Push and pop together at level 5.
      for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, "fill5");
      do_cycle(1'b1, 8'h77, 1'b1, 1'b0, "lvl5_push_pop");
      for (int i = 0; i < 5; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain5");

      // UART transmitter fed with "HELLO".
      do_reset();
      ack_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         logic [39:0] msg;
         msg = "HELLO";
         do_cycle(1'b1, msg[8*(4-i) +: 8], 1'b0, 1'b0, "hello_wr");
      end
      fork
         uart_tx(5);
         uart_rx(5);
      join
      check("uart.ack_count", 32'(ack_cnt), 32'd5);
      check("uart.sb_empty", 32'(sb.size()), 32'd0);
      txd = 1'b1;

      // Reset mid-operation discards queued bytes.
      do_reset();
      for (int i = 0; i < 7; i++) do_cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "fill7");
      do_cycle(1'b1, 8'hEE, 1'b0, 1'b0, "pre_rst");
      do_reset();
      check_model("mid_rst");
      do_cycle(1'b1, 8'h55, 1'b0, 1'b0, "post_rst_wr");
      check("post_rst.data", 32'(u_if.tx_data), 32'h55);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
